if_fetch_stage: RTL and testbench

//  Instruction-fetch stage of the pipelined MIPS CPU: owns the PC register, drives the

---
 rtl/cpu_pkg.sv | 19 +
 rtl/if_id_reg.sv | 24 ++
 rtl/if_fetch_stage.sv | 92 +++++++++
 tb/tb_if_fetch_stage.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: reset/interrupt vectors, the NOP encoding and the IF/ID payload.
package cpu_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] INST_NOP   = 32'h0000_0000;
  localparam logic [XLEN-1:0] RESET_PC   = 32'h0040_0000;
  localparam logic [XLEN-1:0] IRQ_VECTOR = 32'h8000_0004;

  // IF/ID pipeline register payload
  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
  } ifid_t;

  localparam ifid_t IFID_BUBBLE = '{inst: INST_NOP, pc_plus4: 32'h0, valid: 1'b0};

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: bubble beats hold, hold beats load; async clear to a bubble.
module if_id_reg (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          load,
  input  logic          bubble,
  input  cpu_pkg::ifid_t d,
  output cpu_pkg::ifid_t q
);

  import cpu_pkg::*;

  // Register update with bubble/hold/load priority
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= IFID_BUBBLE;
    end else if (bubble) begin
      q <= IFID_BUBBLE;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, interrupt entry and IF/ID capture.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC   = cpu_pkg::RESET_PC,
  parameter logic [31:0] IRQ_VECTOR = cpu_pkg::IRQ_VECTOR
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  input  logic        stall_if,
  input  logic        flush_ifid,
  input  logic        id_jump,
  input  logic [31:0] id_jump_target,
  input  logic        ex_branch,
  input  logic [31:0] ex_branch_tgt,
  input  logic        irq,
  output logic        irq_ack,
  output logic [31:0] irq_epc,
  output logic [31:0] ifid_inst,
  output logic [31:0] ifid_pc_plus4,
  output logic        ifid_valid
);

  import cpu_pkg::*;

  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [31:0] pc_plus4;
  logic        irq_take;
  logic        ifid_bubble;
  ifid_t       ifid_d;
  ifid_t       ifid_q;

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;

  // Interrupts are masked in kernel space and whenever the PC is already being steered
  assign irq_take = irq & ~pc[31] & ~stall_if & ~ex_branch & ~id_jump;

  // Next-PC select: redirects first, then interrupt entry, then stall, then sequential
  always_comb begin
    pc_next = pc_plus4;
    if (ex_branch) begin
      pc_next = ex_branch_tgt;
    end else if (id_jump) begin
      pc_next = id_jump_target;
    end else if (irq_take) begin
      pc_next = IRQ_VECTOR;
    end else if (stall_if) begin
      pc_next = pc;
    end
  end

  // PC register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next;
    end
  end

  // Interrupt entry: save the squashed PC and pulse the acknowledge one cycle later
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_ack <= 1'b0;
      irq_epc <= 32'h0;
    end else begin
      irq_ack <= irq_take;
      if (irq_take) begin
        irq_epc <= pc;
      end
    end
  end

  assign ifid_bubble = ex_branch | id_jump | flush_ifid | irq_take;
  assign ifid_d      = '{inst: imem_inst, pc_plus4: pc_plus4, valid: 1'b1};

  if_id_reg u_if_id_reg (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (~stall_if),
    .bubble  (ifid_bubble),
    .d       (ifid_d),
    .q       (ifid_q)
  );

  assign ifid_inst     = ifid_q.inst;
  assign ifid_pc_plus4 = ifid_q.pc_plus4;
  assign ifid_valid    = ifid_q.valid;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed table-driven bench for if_fetch_stage with a behavioural instruction memory.
module tb_if_fetch_stage;

  logic        clk;
  logic        reset_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic        stall_if;
  logic        flush_ifid;
  logic        id_jump;
  logic [31:0] id_jump_target;
  logic        ex_branch;
  logic [31:0] ex_branch_tgt;
  logic        irq;
  logic        irq_ack;
  logic [31:0] irq_epc;
  logic [31:0] ifid_inst;
  logic [31:0] ifid_pc_plus4;
  logic        ifid_valid;

  int checks = 0;
  int errors = 0;

  if_fetch_stage dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .imem_addr      (imem_addr),
    .imem_inst      (imem_inst),
    .stall_if       (stall_if),
    .flush_ifid     (flush_ifid),
    .id_jump        (id_jump),
    .id_jump_target (id_jump_target),
    .ex_branch      (ex_branch),
    .ex_branch_tgt  (ex_branch_tgt),
    .irq            (irq),
    .irq_ack        (irq_ack),
    .irq_epc        (irq_epc),
    .ifid_inst      (ifid_inst),
    .ifid_pc_plus4  (ifid_pc_plus4),
    .ifid_valid     (ifid_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: fixed word at the reset vector, address-derived pattern elsewhere
  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h0040_0000) return 32'h241a_0001;
    return {a[15:0], a[31:16]} ^ 32'hC0DE_0000;
  endfunction

  always_comb imem_inst = mem(imem_addr);

  typedef struct {
    logic        stall;
    logic        flush;
    logic        jump;
    logic [31:0] jtgt;
    logic        br;
    logic [31:0] btgt;
    logic        irq;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        valid;
    logic        ack;
    logic [31:0] epc;
  } vec_t;

  localparam int NV = 28;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic s, input logic f, input logic j, input logic [31:0] jt,
                              input logic b, input logic [31:0] bt, input logic i,
                              input logic [31:0] pc, input logic [31:0] pc4, input logic v,
                              input logic a, input logic [31:0] e);
    vec_t r;
    r.stall = s; r.flush = f; r.jump = j; r.jtgt = jt; r.br = b; r.btgt = bt; r.irq = i;
    r.pc = pc; r.pc4 = pc4; r.valid = v; r.ack = a; r.epc = e;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    stall_if = v.stall; flush_ifid = v.flush; id_jump = v.jump; id_jump_target = v.jtgt;
    ex_branch = v.br; ex_branch_tgt = v.btgt; irq = v.irq;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, " imem_addr"}, imem_addr, 32'h0040_0000);
    chk({tag, " ifid_inst"}, ifid_inst, 32'h0);
    chk({tag, " ifid_pc_plus4"}, ifid_pc_plus4, 32'h0);
    chk({tag, " ifid_valid"}, 32'(ifid_valid), 32'h0);
    chk({tag, " irq_ack"}, 32'(irq_ack), 32'h0);
    chk({tag, " irq_epc"}, irq_epc, 32'h0);
  endtask

  initial begin
    logic [31:0] exp_inst;
    vec_t idle;
    idle = mk(0,0,0,32'h0,0,32'h0,0, 32'h0,32'h0,0,0,32'h0);

    //            s f j jtgt          b btgt          i  pc            pc4           v a epc
    vecs[0]  = mk(0,0,0,32'h0,        0,32'h0,        0, 32'h0040_0004,32'h0040_0004,1,0,32'h0);
    vecs[1]  = mk(0,0,0,32'h0,        0,32'h0,        0, 32'h0040_0008,32'h0040_0008,1,0,32'h0);
    vecs[2]  = mk(0,0,0,32'h0,        0,32'h0,        0, 32'h0040_000C,32'h0040_000C,1,0,32'h0);
    vecs[3]  = mk(0,0,0,32'h0,        0,32'h0,        0, 32'h0040_0010,32'h0040_0010,1,0,32'h0);
    vecs[4]  = mk(1,0,0,32'h0,        0,32'h0,        0, 32'h0040_0010,32'h0040_0010,1,0,32'h0);
    vecs[5]  = mk(1,0,0,32'h0,        0,32'h0,        0, 32'h0040_0010,32'h0040_0010,1,0,32'h0);
    vecs[6]  = mk(0,0,0,32'h0,        0,32'h0,        0, 32'h0040_0014,32'h0040_0014,1,0,32'h0);
    vecs[7]  = mk(0,0,0,32'h0,        0,32'h0,        0, 32'h0040_0018,32'h0040_0018,1,0,32'h0);
    vecs[8]  = mk(0,0,0,32'h0,        0,32'h0,        0, 32'h0040_001C,32'h0040_001C,1,0,32'h0);
    vecs[9]  = mk(0,0,0,32'h0,        0,32'h0,        0, 32'h0040_0020,32'h0040_0020,1,0,32'h0);
    vecs[10] = mk(0,0,0,32'h0,        0,32'h0,        0, 32'h0040_0024,32'h0040_0024,1,0,32'h0);
    vecs[11] = mk(0,0,0,32'h0,        0,32'h0,        0, 32'h0040_0028,32'h0040_0028,1,0,32'h0);
    vecs[12] = mk(0,0,0,32'h0,        0,32'h0,        0, 32'h0040_002C,32'h0040_002C,1,0,32'h0);
    vecs[13] = mk(0,0,1,32'h0040_0120,0,32'h0,        0, 32'h0040_0120,32'h0,        0,0,32'h0);
    vecs[14] = mk(0,0,0,32'h0,        0,32'h0,        0, 32'h0040_0124,32'h0040_0124,1,0,32'h0);
    vecs[15] = mk(1,0,1,32'h0040_0200,1,32'h0040_0100,0, 32'h0040_0100,32'h0,        0,0,32'h0);
    vecs[16] = mk(0,1,0,32'h0,        0,32'h0,        0, 32'h0040_0104,32'h0,        0,0,32'h0);
    vecs[17] = mk(0,0,0,32'h0,        0,32'h0,        0, 32'h0040_0108,32'h0040_0108,1,0,32'h0);
    vecs[18] = mk(0,0,1,32'h0040_0050,0,32'h0,        0, 32'h0040_0050,32'h0,        0,0,32'h0);
    vecs[19] = mk(0,0,0,32'h0,        0,32'h0,        1, 32'h8000_0004,32'h0,        0,1,32'h0040_0050);
    vecs[20] = mk(0,0,0,32'h0,        0,32'h0,        1, 32'h8000_0008,32'h8000_0008,1,0,32'h0040_0050);
    vecs[21] = mk(0,0,0,32'h0,        0,32'h0,        1, 32'h8000_000C,32'h8000_000C,1,0,32'h0040_0050);
    vecs[22] = mk(0,0,1,32'h0040_0060,0,32'h0,        1, 32'h0040_0060,32'h0,        0,0,32'h0040_0050);
    vecs[23] = mk(1,0,0,32'h0,        0,32'h0,        1, 32'h0040_0060,32'h0,        0,0,32'h0040_0050);
    vecs[24] = mk(0,0,0,32'h0,        0,32'h0,        1, 32'h8000_0004,32'h0,        0,1,32'h0040_0060);
    vecs[25] = mk(0,0,0,32'h0,        0,32'h0,        0, 32'h8000_0008,32'h8000_0008,1,0,32'h0040_0060);
    vecs[26] = mk(0,0,1,32'hFFFF_FFFC,0,32'h0,        0, 32'hFFFF_FFFC,32'h0,        0,0,32'h0040_0060);
    vecs[27] = mk(0,0,0,32'h0,        0,32'h0,        0, 32'h0000_0000,32'h0000_0000,1,0,32'h0040_0060);

    reset_n = 1'b0;
    drive(idle);
    #12;
    check_reset_state("reset");
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i]);
      @(posedge clk);
      @(negedge clk);
      exp_inst = vecs[i].valid ? mem(vecs[i].pc4 - 32'd4) : 32'h0;
      chk($sformatf("v%0d imem_addr", i), imem_addr, vecs[i].pc);
      chk($sformatf("v%0d ifid_inst", i), ifid_inst, exp_inst);
      chk($sformatf("v%0d ifid_pc_plus4", i), ifid_pc_plus4, vecs[i].pc4);
      chk($sformatf("v%0d ifid_valid", i), 32'(ifid_valid), 32'(vecs[i].valid));
      chk($sformatf("v%0d irq_ack", i), 32'(irq_ack), 32'(vecs[i].ack));
      chk($sformatf("v%0d irq_epc", i), irq_epc, vecs[i].epc);
    end

    // Run a few sequential cycles, then drop reset between edges
    drive(idle);
    repeat (3) @(posedge clk);
    #1;
    chk("pre-reset imem_addr", imem_addr, 32'h0000_000C);
    chk("pre-reset ifid_valid", 32'(ifid_valid), 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_state("async reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("post-reset imem_addr", imem_addr, 32'h0040_0004);
    chk("post-reset ifid_inst", ifid_inst, 32'h241a_0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
